// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg: shared FSM encoding, default widths and index-width helper for the hash core arbiter
package hash_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
    localparam int DATA_W_DEF  = 1024;
    localparam int KEY_LEN_DEF = 256;
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/hash_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first pending bit at or after rr_ptr
//   pending  request vector
//   rr_ptr   index that gets first priority
//   winner   one-hot winner, 0 when nothing pending
//   valid    any request pending
module rr_picker import hash_arbiter_pkg::*; #(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);
    logic [N-1:0] rot, oh;
    // Rotate so rr_ptr lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot    = N'({pending, pending} >> rr_ptr);
        oh     = rot & (-rot);
        winner = N'({oh, oh} << rr_ptr >> N);
    end
    assign valid = |pending;
endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin sharing of one sha256XMSS core between NUM_REQ start/done requesters
//   clk, reset                      clock, asynchronous active-high reset
//   req_start/req_data_in/req_*     per-requester start pulse, data and control bits (held until req_done)
//   req_done, req_data_out          done pulse to the owner only, core result broadcast
//   hash_start, hash_data_in, ...   muxed interface to the single core; hash_done/hash_data_out back
//   grant                           one-hot current owner, 0 when idle
//   err_protocol, err_intermediate  sticky error flags
module hash_arbiter import hash_arbiter_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]        req_message_length,
    input  logic [NUM_REQ-1:0]        req_store_intermediate,
    input  logic [NUM_REQ-1:0]        req_continue_intermediate,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [KEY_LEN-1:0]        req_data_out,
    output logic                      hash_start,
    output logic [DATA_W-1:0]         hash_data_in,
    output logic                      message_length,
    output logic                      store_intermediate,
    output logic                      continue_intermediate,
    input  logic                      hash_done,
    input  logic [KEY_LEN-1:0]        hash_data_out,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      err_protocol,
    output logic                      err_intermediate
);
    localparam int IW = idx_w(NUM_REQ);
    state_t state;
    logic [NUM_REQ-1:0] pending, winner, busy;
    logic [IW-1:0] rr_ptr, gidx, win_idx, int_owner;
    logic int_valid, win_valid, done_now;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .pending(pending),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) win_idx = winner[i] ? IW'(i) : win_idx;
    end

    // grant is zero in IDLE, so the AND-OR mux drives zeros there for free.
    always_comb begin
        hash_data_in          = '0;
        message_length        = 1'b0;
        store_intermediate    = 1'b0;
        continue_intermediate = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hash_data_in          = grant[i] ? req_data_in[i*DATA_W +: DATA_W] : hash_data_in;
            message_length        = grant[i] ? req_message_length[i] : message_length;
            store_intermediate    = grant[i] ? req_store_intermediate[i] : store_intermediate;
            continue_intermediate = grant[i] ? req_continue_intermediate[i] : continue_intermediate;
        end
    end

    assign done_now     = (state == WAIT) && hash_done;
    // The owner may restart in the very cycle its done is delivered.
    assign busy         = pending | (done_now ? '0 : grant);
    assign req_done     = done_now ? grant : '0;
    assign req_data_out = hash_data_out;
    assign hash_start   = state == ISSUE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pending          <= '0;
            grant            <= '0;
            gidx             <= '0;
            rr_ptr           <= '0;
            int_owner        <= '0;
            int_valid        <= 1'b0;
            err_protocol     <= 1'b0;
            err_intermediate <= 1'b0;
        end else begin
            pending      <= (pending & ~((state == ISSUE) ? grant : '0)) | (req_start & ~busy);
            err_protocol <= err_protocol | (|(req_start & busy));
            case (state)
                IDLE: if (win_valid) begin
                    state <= ISSUE;
                    grant <= winner;
                    gidx  <= win_idx;
                end
                ISSUE: begin
                    state            <= WAIT;
                    err_intermediate <= err_intermediate |
                                        (continue_intermediate & ~(int_valid & (int_owner == gidx)));
                    if (store_intermediate) begin
                        int_owner <= gidx;
                        int_valid <= 1'b1;
                    end
                end
                WAIT: if (hash_done) begin
                    state  <= IDLE;
                    grant  <= '0;
                    rr_ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed stimulus against a cycle-level behavioural model with a per-cycle compare
module tb_hash_arbiter;
    localparam int NR  = 2;
    localparam int DW  = 1024;
    localparam int KL  = 256;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0] req_start = '0, req_len = '0, req_store = '0, req_cont = '0;
    logic [NR*DW-1:0] req_data_in;
    logic [NR-1:0] req_done, grant;
    logic [KL-1:0] req_data_out, hash_data_out;
    logic [DW-1:0] hash_data_in;
    logic hash_start, message_length, store_intermediate, continue_intermediate;
    logic hash_done, err_protocol, err_intermediate;
    logic spur = 1'b0;
    int n_assert = 0, n_fail = 0, cyc = 0, core_starts = 0, st_cyc = 0;

    hash_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .KEY_LEN(KL)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_start                (req_start),
        .req_data_in              (req_data_in),
        .req_message_length       (req_len),
        .req_store_intermediate   (req_store),
        .req_continue_intermediate(req_cont),
        .req_done                 (req_done),
        .req_data_out             (req_data_out),
        .hash_start               (hash_start),
        .hash_data_in             (hash_data_in),
        .message_length           (message_length),
        .store_intermediate       (store_intermediate),
        .continue_intermediate    (continue_intermediate),
        .hash_done                (hash_done),
        .hash_data_out            (hash_data_out),
        .grant                    (grant),
        .err_protocol             (err_protocol),
        .err_intermediate         (err_intermediate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [NR-1:0] v, input int unsigned i);
        return |(v & (NR'(1) << i));
    endfunction

    // Model: one job at a time; owner is who holds the core, started marks that its start pulse went out.
    typedef struct packed {
        logic        busy;
        logic        started;
        logic [NR-1:0] pend;
        int unsigned owner;
        int unsigned ptr;
        int unsigned iown;
        logic        ival;
        logic        eprot;
        logic        eint;
    } mst_t;
    mst_t m;

    function automatic mst_t step(input mst_t s);
        mst_t n = s;
        logic done = s.busy && s.started && hash_done;
        for (int i = 0; i < NR; i++)
            if (req_start[i]) begin
                if (bit_of(s.pend, i) || (s.busy && s.owner == i && !done)) n.eprot = 1'b1;
                else n.pend = n.pend | (NR'(1) << i);
            end
        if (!s.busy) begin
            for (int k = NR - 1; k >= 0; k--)
                if (bit_of(s.pend, (s.ptr + k) % NR)) begin
                    n.busy  = 1'b1;
                    n.owner = (s.ptr + k) % NR;
                end
            n.started = 1'b0;
        end else if (!s.started) begin
            n.started = 1'b1;
            n.pend    = n.pend & ~(NR'(1) << s.owner);
            if (bit_of(req_cont, s.owner) && !(s.ival && s.iown == s.owner)) n.eint = 1'b1;
            if (bit_of(req_store, s.owner)) begin
                n.ival = 1'b1;
                n.iown = s.owner;
            end
        end else if (hash_done) begin
            n.ptr  = (s.owner + 1) % NR;
            n.busy = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= step(m);
    end

    // Per-cycle compare of every output against the model.
    initial begin
        logic [NR-1:0] eg;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            eg = m.busy ? NR'(1 << m.owner) : '0;
            ed = m.busy ? DW'(req_data_in >> (m.owner * DW)) : '0;
            chk("grant", 256'(grant), 256'(eg));
            chk("hash_start", 256'(hash_start), 256'(m.busy && !m.started));
            chk("req_done", 256'(req_done), 256'((m.busy && m.started && hash_done) ? eg : '0));
            for (int j = 0; j < DW / 256; j++)
                chk("hash_data_in", 256'(hash_data_in >> (j * 256)), 256'(ed >> (j * 256)));
            chk("message_length", 256'(message_length), 256'(m.busy && bit_of(req_len, m.owner)));
            chk("store_intermediate", 256'(store_intermediate), 256'(m.busy && bit_of(req_store, m.owner)));
            chk("continue_intermediate", 256'(continue_intermediate), 256'(m.busy && bit_of(req_cont, m.owner)));
            chk("req_data_out", req_data_out, hash_data_out);
            chk("err_protocol", 256'(err_protocol), 256'(m.eprot));
            chk("err_intermediate", 256'(err_intermediate), 256'(m.eint));
        end
    end

    // Core stand-in: done LAT cycles after each observed start; spur injects a stray done.
    initial begin
        int cnt;
        cnt = 0;
        hash_done = 1'b0;
        hash_data_out = '0;
        forever begin
            @(negedge clk);
            if (reset) cnt = 0;
            else if (hash_start) begin
                cnt = LAT;
                core_starts++;
                st_cyc = cyc;
            end
            @(posedge clk);
            #1;
            hash_done = spur;
            if (reset) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    hash_done = 1'b1;
                    hash_data_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_done(output logic [NR-1:0] who, output int at);
        who = '0;
        at = 0;
        for (int i = 0; i < 40 && who == '0; i++) begin
            @(negedge clk);
            who = req_done;
            at = cyc;
        end
        chk("done_seen", {255'b0, who != '0}, 256'd1);
    endtask

    initial begin
        logic [NR-1:0] who;
        logic [NR-1:0] order [4];
        int t, n0;
        for (int i = 0; i < NR * DW / 32; i++) req_data_in[i*32 +: 32] = $urandom;
        repeat (3) smp();
        chk("rst_grant", 256'(grant), 256'd0);
        chk("rst_start", 256'(hash_start), 256'd0);
        chk("rst_model_idle", {255'b0, m.busy}, 256'd0);
        drv();
        reset = 1'b0;

        // Simultaneous requests with rr_ptr=0: 0 first, 1 issued two cycles after 0's done.
        drv(); req_start = 2'b11;
        drv(); req_start = 2'b00;
        smp();
        chk("sim_wait_grant", 256'(grant), 256'd0);
        drv(); smp();
        chk("sim_start0", 256'(hash_start), 256'd1);
        chk("sim_grant0", 256'(grant), 256'(2'b01));
        wait_done(who, t);
        chk("sim_first", 256'(who), 256'(2'b01));
        chk("sim_latency", 256'(t - st_cyc), 256'(LAT));
        drv(); smp();
        chk("sim_gap", 256'(hash_start), 256'd0);
        drv(); smp();
        chk("sim_start1", 256'(hash_start), 256'd1);
        chk("sim_grant1", 256'(grant), 256'(2'b10));
        chk("sim_start1_cycle", 256'(cyc - t), 256'd2);
        wait_done(who, t);
        chk("sim_second", 256'(who), 256'(2'b10));
        smp();
        chk("sim_ptr_model", 256'(m.ptr), 256'd0);
        chk("sim_ptr_dut", 256'(dut.rr_ptr), 256'd0);

        // Single request from requester 0.
        drv(); req_start = 2'b01;
        drv(); req_start = 2'b00;
        drv(); smp();
        chk("single_start", 256'(hash_start), 256'd1);
        chk("single_data", hash_data_in[255:0], req_data_in[255:0]);
        wait_done(who, t);
        chk("single_done", 256'(who), 256'(2'b01));

        // Stray done while idle must be ignored.
        smp(); spur = 1'b1;
        drv(); smp();
        chk("spur_done", 256'(req_done), 256'd0);
        chk("spur_grant", 256'(grant), 256'd0);
        spur = 1'b0;

        // Fairness: 0 then 1 pending; each re-requests on its first done.
        drv(); req_start = 2'b01;
        drv(); req_start = 2'b10;
        drv(); req_start = 2'b00;
        for (int j = 0; j < 4; j++) begin
            wait_done(who, t);
            order[j] = who;
            if (j < 2) req_start = who;
            drv();
            req_start = 2'b00;
        end
        chk("fair_0", 256'(order[0]), 256'(2'b01));
        chk("fair_1", 256'(order[1]), 256'(2'b10));
        chk("fair_2", 256'(order[2]), 256'(2'b01));
        chk("fair_3", 256'(order[3]), 256'(2'b10));
        chk("fair_no_perr", 256'(err_protocol), 256'd0);

        // Intermediate ownership: 0 stores, 1 continues someone else's state.
        drv(); req_store = 2'b01; req_start = 2'b01;
        drv(); req_start = 2'b00;
        wait_done(who, t);
        chk("int_store_done", 256'(who), 256'(2'b01));
        chk("int_clean", 256'(err_intermediate), 256'd0);
        req_store = 2'b00;
        drv(); req_cont = 2'b10; req_start = 2'b10;
        drv(); req_start = 2'b00;
        wait_done(who, t);
        chk("int_foreign_done", 256'(who), 256'(2'b10));
        chk("int_err", 256'(err_intermediate), 256'd1);
        req_cont = 2'b00;

        // Protocol: restart of requester 1 while it owns the core.
        n0 = core_starts;
        drv(); req_start = 2'b10;
        drv(); req_start = 2'b00;
        drv();
        drv();
        chk("prot_owner", 256'(grant), 256'(2'b10));
        req_start = 2'b10;
        drv(); req_start = 2'b00;
        wait_done(who, t);
        chk("prot_done", 256'(who), 256'(2'b10));
        repeat (8) smp();
        chk("prot_jobs", 256'(core_starts - n0), 256'd1);
        chk("prot_err", 256'(err_protocol), 256'd1);

        // Reset while the core is busy, then a fresh job.
        drv(); req_len = 2'b01; req_start = 2'b01;
        drv(); req_start = 2'b00;
        drv();
        drv();
        chk("rw_pre_grant", 256'(grant), 256'(2'b01));
        chk("rw_pre_len", 256'(message_length), 256'd1);
        reset = 1'b1;
        #1;
        chk("rw_grant", 256'(grant), 256'd0);
        chk("rw_start", 256'(hash_start), 256'd0);
        chk("rw_done", 256'(req_done), 256'd0);
        chk("rw_len", 256'(message_length), 256'd0);
        chk("rw_data", hash_data_in[255:0], 256'd0);
        chk("rw_perr", 256'(err_protocol), 256'd0);
        chk("rw_ierr", 256'(err_intermediate), 256'd0);
        smp();
        drv(); reset = 1'b0; req_len = 2'b00;
        drv(); req_start = 2'b10;
        drv(); req_start = 2'b00;
        wait_done(who, t);
        chk("rw_after", 256'(who), 256'(2'b10));
        chk("rw_after_latency", 256'(t - st_cyc), 256'(LAT));
        repeat (3) smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hash_arbiter.md
# hash_arbiter

Shares one sha256XMSS hash core between NUM_REQ independent requesters (l_tree, WOTS chain, treehash), each of which speaks the core's existing start/done protocol. Requests are round-robin arbitrated. The granted requester's inputs are muxed to the core and its done pulse is routed back to that requester only. The block sits between the XMSS leaf/WOTS engines and the single sha256XMSS instance.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 1024, width of hash_data_in
- KEY_LEN, 256, width of hash_data_out
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_start  in  NUM_REQ  per-requester 1-cycle start pulse
- req_data_in  in  NUM_REQ*DATA_W  flattened, requester i at [i*DATA_W +: DATA_W]
- req_message_length  in  NUM_REQ  per-requester message_length
- req_store_intermediate  in  NUM_REQ  per-requester store_intermediate
- req_continue_intermediate  in  NUM_REQ  per-requester continue_intermediate
- req_done  out  NUM_REQ  1-cycle done pulse to the owning requester
- req_data_out  out  KEY_LEN  core data_out, broadcast to all requesters
- hash_start  out  1  start pulse to the core
- hash_data_in  out  DATA_W  muxed data to the core
- message_length, store_intermediate, continue_intermediate  out  1 each  muxed controls to the core
- hash_done  in  1  core done pulse
- hash_data_out  in  KEY_LEN  core result
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- err_protocol  out  1  sticky protocol-violation flag
- err_intermediate  out  1  sticky foreign-continue flag

## Operation
- pending[NUM_REQ]: req_start[i] sets pending[i]. Cleared when requester i enters ISSUE.
- FSM states:
  - IDLE: if any pending, pick a winner by round-robin starting at rr_ptr, register grant, go to ISSUE. Otherwise stay.
  - ISSUE: drive hash_start=1 for exactly one cycle, clear pending[grant], go to WAIT.
  - WAIT: on hash_done, assert req_done[grant]=1 in the same cycle (combinational AND with grant). Set rr_ptr = (grant index+1) mod NUM_REQ, clear grant, go to IDLE.
- Muxed core inputs select the granted requester during ISSUE and WAIT. They are 0 in IDLE.
- Requesters hold data_in and the control bits stable from req_start until their req_done. The arbiter does not latch data.
- Intermediate ownership: int_owner register plus int_valid bit.
  - An ISSUE with store_intermediate=1 sets int_owner=grant and int_valid=1.
  - An ISSUE with continue_intermediate=1 from a requester other than int_owner, or with int_valid=0, sets err_intermediate. The request is still forwarded.
- Protocol error: req_start[i] while pending[i]=1, or while grant[i]=1, is ignored and sets err_protocol.
- Both error flags clear only on reset.

## Timing
- Reset values:
  - pending=0, grant=0, rr_ptr=0, int_valid=0, state=IDLE
  - hash_start=0, req_done=0, err_protocol=0, err_intermediate=0
  - muxed data/control outputs=0
- Latency: req_start in cycle c → grant registered at end of c+1 → hash_start high in cycle c+2.
- req_done is high in the same cycle as hash_done.
- Back-to-back: a new grant can be issued in the cycle after hash_done (IDLE → ISSUE). Minimum gap between two core starts is core latency + 2.
- Simultaneous starts from all requesters: served in rr_ptr order, one core job at a time. No requester starves; worst-case wait is (NUM_REQ-1) jobs.
- req_start[i] in the same cycle as its own req_done is legal. It sets pending[i], but lower priority follows from the rr_ptr advance.
- hash_done while in IDLE or ISSUE is ignored.
- Reset mid-WAIT: everything returns to reset values. The core shares reset, so no stale done pulse is delivered.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2)
  - DATA_W and KEY_LEN defaults
  - index width `CLOG2(NUM_REQ)
- Sub-module rr_picker: combinational round-robin winner (pending, rr_ptr → one-hot winner, valid). It is reused by the future memory-port arbiter.

## Test plan
- Single request: req_start[0] at cycle 10 → hash_start at cycle 12 with requester-0 data; core done → req_done[0]=1 same cycle, req_done[1]=0.
- Simultaneous: req_start=2'b11 at cycle 10 with rr_ptr=0 → requester 0 served first, requester 1 started the cycle after done+1; rr_ptr ends at 0.
- Fairness: requester 0 re-requests on every req_done, requester 1 held pending → grants alternate 0,1,0,1 over 4 jobs.
- Intermediate: requester 0 stores; requester 1 then issues continue_intermediate=1 → err_intermediate=1, result still returned to requester 1.
- Protocol: second req_start[1] while grant[1]=1 → ignored (exactly one core job), err_protocol=1.
- Reset in WAIT: assert reset mid-job → all outputs 0 immediately; a new req_start afterwards completes normally.
